parallel_serial_tx: RTL and testbench
=====================================

// Module: parallel_serial_tx
// PURPOSE
//   Downstream stage of the universal shift register. Takes WIDTH-bit parallel
//   words over a valid/ready handshake and emits them serially, one bit per clock.
//   - Frame markers on first and last bit; no idle bubble between back-to-back words.
//   - A one-entry holding buffer decouples the producer from the shifter.
// PARAMETERS
//   WIDTH      8   bits per word (>=2)
//   MSB_FIRST  1   1: bit WIDTH-1 transmitted first; 0: bit 0 first
// PORTS
//   clk          input   1      rising-edge clock
//   reset        input   1      asynchronous, active-low reset
//   in_valid     input   1      in_data holds a word
//   in_data      input   WIDTH  parallel word, sampled when in_valid && in_ready
//   in_ready     output  1      holding buffer empty; accept allowed this cycle
//   ser_out      output  1      current serial bit (0 when ser_valid=0)
//   ser_valid    output  1      ser_out carries a data bit this cycle
//   frame_start  output  1      current bit is the first bit of a word
//   frame_done   output  1      current bit is the last bit of a word
//   busy         output  1      shifter active or holding buffer full
// BEHAVIOUR
//   Reset (reset=0, async)
//     - Shifter, holding buffer and bit counter are cleared; FSM = IDLE.
//     - Outputs: in_ready=1; ser_out, ser_valid, frame_start, frame_done, busy = 0.
//     - A frame in progress is abandoned with no completion pulse.
//     - After reset release, the first accept needs a rising edge with reset=1.
//   Registers
//     - hold: data + hold_full.
//     - shifter: WIDTH bits.
//     - bit counter: $clog2(WIDTH) bits.
//   FSM
//     - IDLE: ser_valid=0.
//     - SHIFT: ser_valid=1; counter cnt runs 0..WIDTH-1.
//   Outputs
//     - in_ready = !hold_full. It is a pure function of state and has no
//       combinational path from in_valid.
//     - ser_out = shifter[WIDTH-1] if MSB_FIRST, else shifter[0]. Gated to 0 in IDLE.
//     - frame_start = SHIFT && cnt==0.
//     - frame_done = SHIFT && cnt==WIDTH-1.
//   Definitions
//     - accept = in_valid && in_ready.
//     - free = IDLE || frame_done (shifter can load at this edge).
//   Per rising edge, in priority order:
//     1. free && hold_full: shifter<=hold; hold_full<=0; cnt<=0; ->SHIFT.
//        A simultaneous accept is impossible because in_ready=0.
//     2. free && accept (hold empty): bypass; shifter<=in_data; cnt<=0; ->SHIFT.
//     3. !free && accept: hold<=in_data; hold_full<=1.
//     4. SHIFT && !frame_done: shift toward the output end; cnt<=cnt+1.
//     5. frame_done with nothing pending: ->IDLE; cnt<=0.
//   Latency
//     - Word accepted at edge k while IDLE: first bit is valid in cycle k+1.
//     - Its last bit is in cycle k+WIDTH.
//   Back-to-back
//     - A pending word starts on the cycle immediately after the previous
//       frame_done. ser_valid stays continuously 1.
//   Backpressure
//     - At most one word in the shifter plus one held.
//     - in_ready falls the cycle after the hold fills.
//     - in_ready rises the cycle after the hold drains into the shifter.
//   Width rules
//     - Shift fill value is 0.
//     - cnt never exceeds WIDTH-1.
//     - in_data is never modified in place.
// TESTING
//   1. Reset held low -> in_ready=1; all other outputs 0.
//      Drive reset low mid-frame -> outputs 0 immediately, without waiting for clk.
//   2. WIDTH=8, MSB_FIRST=1, single 0xE5 accepted at edge k ->
//      ser_out 1,1,1,0,0,1,0,1 in cycles k+1..k+8.
//      frame_start in k+1, frame_done in k+8, then ser_valid=0.
//   3. MSB_FIRST=0, 0xE5 -> ser_out 1,0,1,0,0,1,1,1.
//      frame_start/frame_done positions as in test 2.
//   4. 0xE5 then 0x3C offered back-to-back ->
//      16 consecutive ser_valid cycles, bits 11100101 00111100.
//      frame_done/frame_start adjacent at cycles 8/9.
//   5. in_valid held high with 0xE5, 0x3C, 0xA7 ->
//      in_ready=0 from the cycle after 0x3C is held until 0xE5's frame_done edge.
//      0xA7 is accepted next; all 24 bits arrive in order with no loss or duplication.
//   6. Reset pulsed at bit 4 of 0xE5 with 0x3C held ->
//      both words dropped; the next accepted 0x81 transmits cleanly as 10000001.

Source files
------------

// File: rtl/parallel_serial_tx_if.sv
// parallel_serial_tx_if: word handshake in, framed serial bit stream out.
interface parallel_serial_tx_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_start;
    logic             frame_done;
    logic             busy;
    modport master (
        output in_valid, in_data,
        input  in_ready, ser_out, ser_valid, frame_start, frame_done, busy
    );
    modport slave (
        input  in_valid, in_data,
        output in_ready, ser_out, ser_valid, frame_start, frame_done, busy
    );
endinterface

// File: rtl/parallel_serial_tx.sv
// parallel_serial_tx: parallel words in over valid/ready, one bit per clock out,
// with a one-entry holding buffer so consecutive words stream without a bubble.
module parallel_serial_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic                  clk,
    input logic                  reset,
    parallel_serial_tx_if.slave  s
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           state, state_nx;
    logic [WIDTH-1:0] shifter, sh_nx, hold, hold_nx, shifted;
    logic             hold_full, hf_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             accept, free, last;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shifter   <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_nx;
            shifter   <= sh_nx;
            hold      <= hold_nx;
            hold_full <= hf_nx;
            cnt       <= cnt_nx;
        end
    end
    assign last    = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
    assign free    = (state == IDLE) || last;
    assign accept  = s.in_valid && !hold_full;
    assign shifted = MSB_FIRST ? {shifter[WIDTH-2:0], 1'b0} : {1'b0, shifter[WIDTH-1:1]};
    // A held word always wins the free shifter; in_ready is low then, so no accept can collide.
    always_comb begin
        state_nx = state;
        sh_nx    = shifter;
        hold_nx  = hold;
        hf_nx    = hold_full;
        cnt_nx   = cnt;
        if (free && hold_full) begin
            sh_nx    = hold;
            hf_nx    = 1'b0;
            cnt_nx   = '0;
            state_nx = SHIFT;
        end else if (free && accept) begin
            sh_nx    = s.in_data;
            cnt_nx   = '0;
            state_nx = SHIFT;
        end else begin
            if (accept) begin
                hold_nx = s.in_data;
                hf_nx   = 1'b1;
            end
            if (last) begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end else if (state == SHIFT) begin
                sh_nx  = shifted;
                cnt_nx = cnt + CW'(1);
            end
        end
    end
    assign s.in_ready    = !hold_full;
    assign s.ser_valid   = (state == SHIFT);
    assign s.ser_out     = (state == SHIFT) && (MSB_FIRST ? shifter[WIDTH-1] : shifter[0]);
    assign s.frame_start = (state == SHIFT) && (cnt == '0);
    assign s.frame_done  = last;
    assign s.busy        = (state == SHIFT) || hold_full;
endmodule

// File: tb/tb_parallel_serial_tx.sv
// tb_parallel_serial_tx: MSB-first and LSB-first instances driven in lockstep,
// checked against a bit-level scoreboard filled on every accepted word.
module tb_parallel_serial_tx;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    parallel_serial_tx_if #(.WIDTH(8)) m_if ();
    parallel_serial_tx_if #(.WIDTH(8)) l_if ();
    parallel_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .reset(reset), .s(m_if.slave));
    parallel_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .reset(reset), .s(l_if.slave));

    // seq_* lists the transmitted bits with the first bit in position 7
    typedef struct packed {logic bm; logic bl; logic fs; logic fd;} exp_t;
    typedef struct {logic [7:0] data; logic [7:0] seq_m; logic [7:0] seq_l;} vec_t;
    exp_t sb[$];
    vec_t vecs[6];
    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] cur_m, cur_l;
    logic acc;
    int n;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic v, logic [7:0] d, logic [7:0] sm, logic [7:0] sl);
        m_if.in_valid = v;
        l_if.in_valid = v;
        m_if.in_data  = d;
        l_if.in_data  = d;
        cur_m = sm;
        cur_l = sl;
    endtask

    task automatic tick();
        exp_t e;
        logic pend;
        @(posedge clk);
        acc = reset && m_if.in_valid && m_if.in_ready;
        if (acc)
            for (int i = 0; i < 8; i++)
                sb.push_back({cur_m[7-i], cur_l[7-i], i == 0, i == 7});
        @(negedge clk);
        pend = (sb.size() != 0);
        check("ready_match", 32'(m_if.in_ready), 32'(l_if.in_ready));
        check("valid_m", 32'(m_if.ser_valid), 32'(pend));
        check("valid_l", 32'(l_if.ser_valid), 32'(pend));
        check("busy_m", 32'(m_if.busy), 32'(pend));
        check("busy_l", 32'(l_if.busy), 32'(pend));
        e = pend ? sb.pop_front() : '0;
        check("bit_m", 32'(m_if.ser_out), 32'(e.bm));
        check("bit_l", 32'(l_if.ser_out), 32'(e.bl));
        check("start_m", 32'(m_if.frame_start), 32'(e.fs));
        check("start_l", 32'(l_if.frame_start), 32'(e.fs));
        check("done_m", 32'(m_if.frame_done), 32'(e.fd));
        check("done_l", 32'(l_if.frame_done), 32'(e.fd));
    endtask

    task automatic offer(vec_t v, output int cycles);
        drive(1'b1, v.data, v.seq_m, v.seq_l);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!acc && cycles < 50);
        check("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        int k = 0;
        drive(1'b0, 8'h00, 8'h00, 8'h00);
        while ((sb.size() != 0 || m_if.busy || l_if.busy) && k < 60) begin
            tick();
            k++;
        end
        check("drain_timeout", 32'(sb.size() == 0 && !m_if.busy && !l_if.busy), 32'd1);
    endtask

    initial begin
        vecs[0] = '{8'hE5, 8'hE5, 8'hA7};
        vecs[1] = '{8'h3C, 8'h3C, 8'h3C};
        vecs[2] = '{8'hA7, 8'hA7, 8'hE5};
        vecs[3] = '{8'h81, 8'h81, 8'h81};
        vecs[4] = '{8'h01, 8'h01, 8'h80};
        vecs[5] = '{8'hF0, 8'hF0, 8'h0F};
        drive(1'b1, 8'hE5, 8'hE5, 8'hA7);
        repeat (3) tick();
        check("rst_ready", 32'(m_if.in_ready), 32'd1);
        check("rst_busy", 32'(m_if.busy), 32'd0);
        reset = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 8'h00);
        tick();

        // single words, idle between them
        for (int i = 0; i < 6; i++) begin
            offer(vecs[i], n);
            drain();
        end

        // two words back-to-back: second lands in the hold one edge later
        offer(vecs[0], n);
        offer(vecs[1], n);
        check("b2b_accept_gap", 32'(n), 32'd1);
        drain();

        // three words with valid held high: third waits for the first frame_done
        offer(vecs[0], n);
        offer(vecs[1], n);
        check("hold_ready_low", 32'(m_if.in_ready), 32'd0);
        offer(vecs[2], n);
        check("third_accept_wait", 32'(n), 32'd8);
        drain();

        // async reset at bit 4 with a word held
        offer(vecs[0], n);
        offer(vecs[1], n);
        drive(1'b0, 8'h00, 8'h00, 8'h00);
        repeat (3) tick();
        #2 reset = 1'b0;
        #1;
        check("arst_valid", 32'(m_if.ser_valid | l_if.ser_valid), 32'd0);
        check("arst_out", 32'(m_if.ser_out | l_if.ser_out), 32'd0);
        check("arst_marks", 32'(m_if.frame_start | m_if.frame_done | l_if.frame_start | l_if.frame_done), 32'd0);
        check("arst_busy", 32'(m_if.busy | l_if.busy), 32'd0);
        check("arst_ready", 32'(m_if.in_ready & l_if.in_ready), 32'd1);
        sb.delete();
        tick();
        tick();
        reset = 1'b1;
        offer(vecs[3], n);
        drain();
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
